// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the keypad scanner and the movement controller.
package keypad_scanner_pkg;

    localparam int unsigned ROWS   = 4;
    localparam int unsigned COLS   = 4;
    localparam int unsigned ROW_W  = 2;
    localparam int unsigned COL_W  = 2;
    localparam int unsigned CODE_W = 4;

    // Scanner FSM states
    typedef enum logic [1:0] {
        ST_SCAN      = 2'd0,
        ST_DEB_PRESS = 2'd1,
        ST_HELD      = 2'd2,
        ST_DEB_REL   = 2'd3
    } kp_state_e;

    // Position of a closed key in the matrix; {row, col} doubles as the map index
    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } key_pos_t;

    // Row/column to hex code map, nibble index = {row, col}
    //   r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: *(E) 0 #(F) D
    localparam logic [ROWS*COLS*CODE_W-1:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

    // Movement key codes shared with the movement controller
    localparam logic [CODE_W-1:0] KEY_UP    = 4'h2;
    localparam logic [CODE_W-1:0] KEY_LEFT  = 4'h4;
    localparam logic [CODE_W-1:0] KEY_RIGHT = 4'h6;
    localparam logic [CODE_W-1:0] KEY_DOWN  = 4'h8;

    // Hex code of the key at a matrix position
    function automatic logic [CODE_W-1:0] key_lookup(input key_pos_t pos);
        logic [5:0] base;
        base = {pos, 2'b00};
        return KEY_MAP[base +: CODE_W];
    endfunction

    // Lowest-numbered row that is pulled low (rows are active-low)
    function automatic logic [ROW_W-1:0] lowest_low_row(input logic [ROWS-1:0] rows_n);
        logic [ROW_W-1:0] r;
        if (!rows_n[0])      r = 2'd0;
        else if (!rows_n[1]) r = 2'd1;
        else if (!rows_n[2]) r = 2'd2;
        else                 r = 2'd3;
        return r;
    endfunction

    // Active-low one-hot drive pattern for a column index
    function automatic logic [COLS-1:0] col_drive(input logic [COL_W-1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer; flops reset to all-ones to match pulled-up idle lines.
module keypad_sync #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Metastability stage followed by the stable output stage
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with press/release debounce and a
// single-cycle strobe per accepted press.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 50000,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic              clk_50MHz_i,
    input  logic              rst_async_la_i,
    input  logic [ROWS-1:0]   row_i,
    output logic [COLS-1:0]   col_o,
    output logic [CODE_W-1:0] key_code_o,
    output logic              key_valid_o,
    output logic              key_down_o
);

    localparam int unsigned DWELL_W = $clog2(SCAN_DIV);
    localparam int unsigned DEB_W   = $clog2(DEBOUNCE_CYCLES);

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);

    logic [ROWS-1:0]   row_s;

    kp_state_e         state_q, state_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DEB_W-1:0]  deb_q, deb_d;
    key_pos_t          pos_q, pos_d;
    logic [COLS-1:0]   col_q, col_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              valid_q, valid_d;
    logic              down_q, down_d;

    logic              dwell_last_c;
    logic              deb_last_c;
    logic              any_low_c;
    logic              lat_high_c;

    keypad_sync #(
        .WIDTH (ROWS)
    ) u_sync (
        .clk_i  (clk_50MHz_i),
        .rst_ni (rst_async_la_i),
        .d_i    (row_i),
        .q_o    (row_s)
    );

    // Conditions shared by the next-state and datapath logic
    assign dwell_last_c = (dwell_q == DWELL_LAST);
    assign deb_last_c   = (deb_q == DEB_LAST);
    assign any_low_c    = ~(&row_s);
    assign lat_high_c   = row_s[pos_q.row];

    // FSM state register
    always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
        if (!rst_async_la_i) begin
            state_q <= ST_SCAN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_SCAN: begin
                if (dwell_last_c && any_low_c) begin
                    state_d = ST_DEB_PRESS;
                end
            end
            ST_DEB_PRESS: begin
                if (lat_high_c) begin
                    state_d = ST_SCAN;
                end else if (deb_last_c) begin
                    state_d = ST_HELD;
                end
            end
            ST_HELD: begin
                if (lat_high_c) begin
                    state_d = ST_DEB_REL;
                end
            end
            ST_DEB_REL: begin
                if (lat_high_c && deb_last_c) begin
                    state_d = ST_SCAN;
                end
            end
            default: state_d = ST_SCAN;
        endcase
    end

    // Counter, latch and output next values; column stays frozen outside SCAN
    always_comb begin
        dwell_d = dwell_q;
        deb_d   = deb_q;
        pos_d   = pos_q;
        code_d  = code_q;
        valid_d = 1'b0;

        unique case (state_q)
            ST_SCAN: begin
                deb_d = '0;
                if (dwell_last_c) begin
                    dwell_d = '0;
                    if (any_low_c) begin
                        pos_d.row = lowest_low_row(row_s);
                    end else begin
                        pos_d.col = pos_q.col + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + DWELL_W'(1);
                end
            end
            ST_DEB_PRESS: begin
                if (lat_high_c) begin
                    pos_d.col = pos_q.col + 2'd1;
                end else if (deb_last_c) begin
                    code_d  = key_lookup(pos_q);
                    valid_d = 1'b1;
                end else begin
                    deb_d = deb_q + DEB_W'(1);
                end
            end
            ST_HELD: begin
                deb_d = '0;
            end
            ST_DEB_REL: begin
                if (!lat_high_c) begin
                    deb_d = '0;
                end else if (deb_last_c) begin
                    pos_d.col = pos_q.col + 2'd1;
                end else begin
                    deb_d = deb_q + DEB_W'(1);
                end
            end
            default: begin
                dwell_d = '0;
                deb_d   = '0;
            end
        endcase

        // Every state starts with fresh counters
        if (state_d != state_q) begin
            dwell_d = '0;
            deb_d   = '0;
        end

        col_d  = col_drive(pos_d.col);
        down_d = (state_d == ST_HELD) || (state_d == ST_DEB_REL);
    end

    // Datapath and output registers
    always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
        if (!rst_async_la_i) begin
            dwell_q <= '0;
            deb_q   <= '0;
            pos_q   <= '0;
            col_q   <= 4'b1110;
            code_q  <= 4'h0;
            valid_q <= 1'b0;
            down_q  <= 1'b0;
        end else begin
            dwell_q <= dwell_d;
            deb_q   <= deb_d;
            pos_q   <= pos_d;
            col_q   <= col_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            down_q  <= down_d;
        end
    end

    assign col_o       = col_q;
    assign key_code_o  = code_q;
    assign key_valid_o = valid_q;
    assign key_down_o  = down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CYCLES=8.
module tb_keypad_scanner;

    localparam int unsigned SD = 4;
    localparam int unsigned DB = 8;

    logic       clk;
    logic       rst_n;
    logic [3:0] row_i;
    logic [3:0] col_o;
    logic [3:0] key_code_o;
    logic       key_valid_o;
    logic       key_down_o;

    logic [15:0] held;
    logic [3:0]  exp_q[$];
    logic [3:0]  exp_code_m;
    logic        prev_valid = 1'b0;

    int total     = 0;
    int bad       = 0;
    int pulse_cnt = 0;

    typedef struct {
        int unsigned row;
        int unsigned col;
        int unsigned hold;
        bit          pulse;
        logic [3:0]  code;
    } vec_t;

    vec_t vecs[18];

    keypad_scanner #(
        .SCAN_DIV        (SD),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk_50MHz_i    (clk),
        .rst_async_la_i (rst_n),
        .row_i          (row_i),
        .col_o          (col_o),
        .key_code_o     (key_code_o),
        .key_valid_o    (key_valid_o),
        .key_down_o     (key_down_o)
    );

    initial begin
        clk = 1'b0;
        #50;
        forever #10 clk = ~clk;
    end

    // Keypad matrix model: a held key pulls its row low while its column is driven
    always_comb begin
        row_i = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (held[r*4+c] && !col_o[c]) row_i[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every strobe must match the oldest expected code
    always @(negedge clk) begin
        if (rst_n === 1'b1 && key_valid_o === 1'b1) begin
            pulse_cnt++;
            check("valid_single_cycle", 32'(prev_valid), 0);
            check("down_on_valid", 32'(key_down_o), 1);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got code %0h want no pulse", key_code_o);
            end else begin
                exp_code_m = exp_q.pop_front();
                check("pulse_code", 32'(key_code_o), 32'(exp_code_m));
            end
        end
        prev_valid = key_valid_o;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait for the first negedge on which the target column has just been driven
    task automatic wait_col_entry(input logic [3:0] target);
        bit left;
        bit found;
        left  = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clk);
            if (col_o !== target) left = 1'b1;
            else if (left) found = 1'b1;
        end
        check("col_align", 32'(found), 1);
    endtask

    initial begin
        int p0;
        int n;

        held  = '0;
        rst_n = 1'b1;

        // Reset with no clock running
        #2 rst_n = 1'b0;
        #5;
        check("rst_col", 32'(col_o), 32'h0000_000E);
        check("rst_code", 32'(key_code_o), 0);
        check("rst_valid", 32'(key_valid_o), 0);
        check("rst_down", 32'(key_down_o), 0);
        cycles(3);
        rst_n = 1'b1;
        check("post_rst_col", 32'(col_o), 32'h0000_000E);

        // Every key once, then two glitches that must be rejected
        vecs[0]  = '{0, 0, 40, 1, 4'h1};
        vecs[1]  = '{0, 1, 40, 1, 4'h2};
        vecs[2]  = '{0, 2, 40, 1, 4'h3};
        vecs[3]  = '{0, 3, 40, 1, 4'hA};
        vecs[4]  = '{1, 0, 40, 1, 4'h4};
        vecs[5]  = '{1, 1, 40, 1, 4'h5};
        vecs[6]  = '{1, 2, 40, 1, 4'h6};
        vecs[7]  = '{1, 3, 40, 1, 4'hB};
        vecs[8]  = '{2, 0, 40, 1, 4'h7};
        vecs[9]  = '{2, 1, 40, 1, 4'h8};
        vecs[10] = '{2, 2, 40, 1, 4'h9};
        vecs[11] = '{2, 3, 40, 1, 4'hC};
        vecs[12] = '{3, 0, 40, 1, 4'hE};
        vecs[13] = '{3, 1, 40, 1, 4'h0};
        vecs[14] = '{3, 2, 40, 1, 4'hF};
        vecs[15] = '{3, 3, 40, 1, 4'hD};
        vecs[16] = '{2, 1, 5, 0, 4'hD};
        vecs[17] = '{0, 0, 5, 0, 4'hD};

        foreach (vecs[k]) begin
            p0 = pulse_cnt;
            if (vecs[k].pulse) exp_q.push_back(vecs[k].code);
            held[vecs[k].row*4 + vecs[k].col] = 1'b1;
            cycles(int'(vecs[k].hold));
            held = '0;
            cycles(24);
            check($sformatf("vec%0d_pulses", k), 32'(pulse_cnt - p0), vecs[k].pulse ? 1 : 0);
            check($sformatf("vec%0d_code", k), 32'(key_code_o), 32'(vecs[k].code));
            check($sformatf("vec%0d_down", k), 32'(key_down_o), 0);
        end

        // Clean press of "6": down lasts 2 sync + 1 HELD + DB release cycles, then column 3
        p0 = pulse_cnt;
        exp_q.push_back(4'h6);
        held[1*4+2] = 1'b1;
        cycles(40);
        check("six_down_held", 32'(key_down_o), 1);
        held = '0;
        n = 0;
        while (key_down_o && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("six_release_len", 32'(n), 32'(3 + DB));
        check("six_resume_col3", 32'(col_o), 32'h0000_0007);
        check("six_pulses", 32'(pulse_cnt - p0), 1);

        // Bounce on press of "2": first debounce aborts, re-detected a rotation later
        cycles(8);
        wait_col_entry(4'b1101);
        p0 = pulse_cnt;
        exp_q.push_back(4'h2);
        for (int i = 0; i <= 40; i++) begin
            if (i == 0 || i == 4) held[0*4+1] = 1'b1;
            if (i == 3 || i == 36) held[0*4+1] = 1'b0;
            if (i == 5)  check("bnc_col_frozen", 32'(col_o), 32'h0000_000D);
            if (i == 6)  check("bnc_col_abort", 32'(col_o), 32'h0000_000B);
            if (i == 29) check("bnc_no_early_valid", 32'(key_valid_o), 0);
            if (i == 30) check("bnc_valid_time", 32'(key_valid_o), 1);
            @(negedge clk);
        end
        cycles(24);
        check("bnc_pulses", 32'(pulse_cnt - p0), 1);

        // Glitch on "8": debounce aborts, code unchanged, scanning continues
        wait_col_entry(4'b1101);
        p0 = pulse_cnt;
        for (int i = 0; i <= 12; i++) begin
            if (i == 0) held[2*4+1] = 1'b1;
            if (i == 5) held[2*4+1] = 1'b0;
            if (i == 7) check("glt_col_frozen", 32'(col_o), 32'h0000_000D);
            if (i == 8) check("glt_col_abort", 32'(col_o), 32'h0000_000B);
            @(negedge clk);
        end
        cycles(20);
        check("glt_pulses", 32'(pulse_cnt - p0), 0);
        check("glt_code_kept", 32'(key_code_o), 32'h2);

        // "4" held, "6" pressed alongside, then a bouncy release of "4"
        wait_col_entry(4'b1110);
        p0 = pulse_cnt;
        exp_q.push_back(4'h4);
        for (int i = 0; i <= 40; i++) begin
            if (i == 0 || i == 23) held[1*4+0] = 1'b1;
            if (i == 20 || i == 24) held[1*4+0] = 1'b0;
            if (i == 16) held[1*4+2] = 1'b1;
            if (i == 18) held[1*4+2] = 1'b0;
            if (i == 12) check("rel_valid_time", 32'(key_valid_o), 1);
            if (i == 31) check("rel_not_early", 32'(key_down_o), 1);
            if (i == 33) check("rel_down_last", 32'(key_down_o), 1);
            if (i == 34) begin
                check("rel_down_off", 32'(key_down_o), 0);
                check("rel_col_next", 32'(col_o), 32'h0000_000D);
            end
            @(negedge clk);
        end
        cycles(20);
        check("rel_pulses", 32'(pulse_cnt - p0), 1);

        // Reset while "8" is held; key stays down across reset release
        wait_col_entry(4'b1101);
        p0 = pulse_cnt;
        exp_q.push_back(4'h8);
        held[2*4+1] = 1'b1;
        cycles(20);
        check("rh_down_before", 32'(key_down_o), 1);
        rst_n = 1'b0;
        #1;
        check("rh_col", 32'(col_o), 32'h0000_000E);
        check("rh_code", 32'(key_code_o), 0);
        check("rh_valid", 32'(key_valid_o), 0);
        check("rh_down", 32'(key_down_o), 0);
        cycles(3);
        rst_n = 1'b1;
        exp_q.push_back(4'h8);
        for (int i = 0; i < 60 && (pulse_cnt - p0) < 2; i++) @(negedge clk);
        check("rh_redetect", 32'(pulse_cnt - p0), 2);
        check("rh_code_after", 32'(key_code_o), 32'h8);
        held = '0;
        cycles(24);
        check("rh_down_after", 32'(key_down_o), 0);
        check("rh_pulses", 32'(pulse_cnt - p0), 2);

        cycles(30);
        check("queue_empty", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
